// File: rtl/mem_stall_ctrl.sv
// Pipeline stall controller for the 5-stage core.
// Latches each memory port's response independently, so either the
// instruction or the data memory may finish first without the port being
// re-requested. It drives lockstep stall enables for every pipeline register
// and keeps saturating stall-cycle performance counters.
module mem_stall_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req_i,
    input  logic                imem_resp_i,
    input  logic                dmem_req_i,
    input  logic                dmem_resp_i,
    input  logic                clear_cnt_i,
    output logic [NUM_REGS-1:0] stall_o,
    output logic                pc_stall_o,
    output logic                imem_read_o,
    output logic                dmem_req_o,
    output logic [CNT_W-1:0]    stall_cycles_o,
    output logic [CNT_W-1:0]    imiss_cycles_o,
    output logic [CNT_W-1:0]    dmiss_cycles_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Response already received for the current pipeline step
    logic i_done;
    logic d_done;

    logic i_ok;
    logic d_ok;
    logic advance;
    logic imiss_inc;
    logic dmiss_inc;

    // Saturating increment: the counter stops at all ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_ONE;
    endfunction

    // Decide whether the pipeline moves this cycle and what to request
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        i_ok        = ~imem_req_i | i_done | imem_resp_i;
        d_ok        = ~dmem_req_i | d_done | dmem_resp_i;
        advance     = i_ok & d_ok & ~rst;
        stall_o     = {NUM_REGS{~advance}};
        pc_stall_o  = ~advance;
        imem_read_o = imem_req_i & ~i_done & ~rst;
        dmem_req_o  = dmem_req_i & ~d_done & ~rst;
        imiss_inc   = imem_req_i & ~i_done & ~imem_resp_i;
        dmiss_inc   = dmem_req_i & ~d_done & ~dmem_resp_i;
    end

    // Remember a port's response until the whole pipeline advances
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the values from before the edge.
        if (rst) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else if (advance) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            if (imem_req_i && imem_resp_i) begin
                i_done <= 1'b1;
            end
            if (dmem_req_i && dmem_resp_i) begin
                d_done <= 1'b1;
            end
        end
    end

    // Performance counters; clearing wins over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_o <= '0;
            imiss_cycles_o <= '0;
            dmiss_cycles_o <= '0;
        end else if (clear_cnt_i) begin
            stall_cycles_o <= '0;
            imiss_cycles_o <= '0;
            dmiss_cycles_o <= '0;
        end else begin
            if (!advance) begin
                stall_cycles_o <= sat_inc(stall_cycles_o);
            end
            if (imiss_inc) begin
                imiss_cycles_o <= sat_inc(imiss_cycles_o);
            end
            if (dmiss_inc) begin
                dmiss_cycles_o <= sat_inc(dmiss_cycles_o);
            end
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl (NUM_REGS=4, CNT_W=8).
// A behavioural model tracks which responses the current pipeline step has
// seen and counts cycles as integers. The model is checked against the DUT
// on every falling edge. Directed scenarios also pin literal values.
module tb_mem_stall_ctrl;

    localparam int NUM_REGS = 4;
    localparam int CNT_W    = 8;
    localparam int CNT_SAT  = 255;

    logic                clk = 1'b0;
    logic                rst;
    logic                imem_req_i;
    logic                imem_resp_i;
    logic                dmem_req_i;
    logic                dmem_resp_i;
    logic                clear_cnt_i;
    logic [NUM_REGS-1:0] stall_o;
    logic                pc_stall_o;
    logic                imem_read_o;
    logic                dmem_req_o;
    logic [CNT_W-1:0]    stall_cycles_o;
    logic [CNT_W-1:0]    imiss_cycles_o;
    logic [CNT_W-1:0]    dmiss_cycles_o;

    int checks = 0;
    int errors = 0;

    mem_stall_ctrl #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_i     (imem_req_i),
        .imem_resp_i    (imem_resp_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_resp_i    (dmem_resp_i),
        .clear_cnt_i    (clear_cnt_i),
        .stall_o        (stall_o),
        .pc_stall_o     (pc_stall_o),
        .imem_read_o    (imem_read_o),
        .dmem_req_o     (dmem_req_o),
        .stall_cycles_o (stall_cycles_o),
        .imiss_cycles_o (imiss_cycles_o),
        .dmiss_cycles_o (dmiss_cycles_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // "Has this port already answered for the step in flight?"
    bit m_i_seen;
    bit m_d_seen;
    int m_stall;
    int m_imiss;
    int m_dmiss;

    // The pipeline may move only when every port it needs has answered
    bit m_i_ready;
    bit m_d_ready;
    bit m_adv;
    assign m_i_ready = !imem_req_i || m_i_seen || imem_resp_i;
    assign m_d_ready = !dmem_req_i || m_d_seen || dmem_resp_i;
    assign m_adv     = !rst && m_i_ready && m_d_ready;

    function automatic int bump(input int v);
        return (v >= CNT_SAT) ? CNT_SAT : v + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_i_seen <= 1'b0;
            m_d_seen <= 1'b0;
            m_stall  <= 0;
            m_imiss  <= 0;
            m_dmiss  <= 0;
        end else begin
            m_i_seen <= m_adv ? 1'b0 : (m_i_seen || (imem_req_i && imem_resp_i));
            m_d_seen <= m_adv ? 1'b0 : (m_d_seen || (dmem_req_i && dmem_resp_i));
            if (clear_cnt_i) begin
                m_stall <= 0;
                m_imiss <= 0;
                m_dmiss <= 0;
            end else begin
                if (!m_adv) m_stall <= bump(m_stall);
                if (imem_req_i && !m_i_seen && !imem_resp_i) m_imiss <= bump(m_imiss);
                if (dmem_req_i && !m_d_seen && !dmem_resp_i) m_dmiss <= bump(m_dmiss);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle, away from the rising edge
    always @(negedge clk) begin
        check("model stall_o", 64'(stall_o), 64'({NUM_REGS{!m_adv}}));
        check("model pc_stall_o", 64'(pc_stall_o), 64'(!m_adv));
        check("model imem_read_o", 64'(imem_read_o), 64'(!rst && imem_req_i && !m_i_seen));
        check("model dmem_req_o", 64'(dmem_req_o), 64'(!rst && dmem_req_i && !m_d_seen));
        check("model stall_cycles_o", 64'(stall_cycles_o), 64'(m_stall));
        check("model imiss_cycles_o", 64'(imiss_cycles_o), 64'(m_imiss));
        check("model dmiss_cycles_o", 64'(dmiss_cycles_o), 64'(m_dmiss));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic ireq, input logic iresp, input logic dreq,
                         input logic dresp, input logic clr);
        imem_req_i  = ireq;
        imem_resp_i = iresp;
        dmem_req_i  = dreq;
        dmem_resp_i = dresp;
        clear_cnt_i = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_counts(input string tag, input int s, input int i, input int d);
        check({tag, " stall_cycles"}, 64'(stall_cycles_o), 64'(s));
        check({tag, " imiss_cycles"}, 64'(imiss_cycles_o), 64'(i));
        check({tag, " dmiss_cycles"}, 64'(dmiss_cycles_o), 64'(d));
    endtask

    initial begin
        // Reset with every input high
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        check("reset stall_o", 64'(stall_o), 64'hF);
        check("reset pc_stall_o", 64'(pc_stall_o), 64'd1);
        check("reset imem_read_o", 64'(imem_read_o), 64'd0);
        check("reset dmem_req_o", 64'(dmem_req_o), 64'd0);
        check_counts("reset", 0, 0, 0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("release stall_o", 64'(stall_o), 64'h0);
        tick();

        // Fetch only, response after three wait cycles
        clear_counters();
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            #1 check("fetch wait stall_o", 64'(stall_o), 64'hF);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("fetch done stall_o", 64'(stall_o), 64'h0);
        tick();
        check_counts("fetch", 3, 3, 0);

        // Load: instruction at cycle 1, data at cycle 4
        clear_counters();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("load imem_read_o after i resp", 64'(imem_read_o), 64'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 check("load advance stall_o", 64'(stall_o), 64'h0);
        tick();
        check_counts("load", 4, 1, 4);

        // Store: data at cycle 2, instruction at cycle 5
        clear_counters();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("store dmem_req_o after d resp", 64'(dmem_req_o), 64'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("store advance pc_stall_o", 64'(pc_stall_o), 64'd0);
        tick();
        check_counts("store", 5, 5, 2);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 check("store next imem_read_o", 64'(imem_read_o), 64'd1);
        check("store next dmem_req_o", 64'(dmem_req_o), 64'd1);
        tick();

        // Both responses in the first request cycle
        clear_counters();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 check("simul stall_o", 64'(stall_o), 64'h0);
        tick();
        check_counts("simul", 0, 0, 0);

        // Response with its request low is ignored; duplicate response too
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("stray resp imem_read_o", 64'(imem_read_o), 64'd1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("dup resp imem_read_o", 64'(imem_read_o), 64'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();

        // Reset in the middle of a stall with d already latched
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
        #2 rst = 1'b1;
        #1 check("midrst dmem_req_o", 64'(dmem_req_o), 64'd0);
        check_counts("midrst", 0, 0, 0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #1 check("after midrst dmem_req_o", 64'(dmem_req_o), 64'd1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();

        // Saturation, then clear during the stall
        clear_counters();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (300) tick();
        check_counts("saturate", CNT_SAT, CNT_SAT, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        check("clear stall_cycles", 64'(stall_cycles_o), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("post clear stall_cycles", 64'(stall_cycles_o), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Parametrised pipeline stall controller that sits between the instruction/data memory ports and the pipeline registers of the 5-stage core. It generalises the single-sided "data response seen" latch to symmetric per-port response latching, so either memory may finish first without re-requesting. It drives a width-parametrised vector of pipeline-register stall enables and exposes saturating stall-cycle performance counters.

## Interface
- NUM_REGS, default 4: number of pipeline registers driven; index 0 = IF/ID … NUM_REGS-1 = MEM/WB.
- CNT_W, default 32: width of each performance counter, minimum 8.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- imem_req_i  input  1  fetch stage wants an instruction this cycle.
- imem_resp_i  input  1  instruction memory response valid (one-cycle pulse).
- dmem_req_i  input  1  MEM-stage control word has mem_read or mem_write set.
- dmem_resp_i  input  1  data memory response valid (one-cycle pulse).
- clear_cnt_i  input  1  synchronous clear of all counters.
- stall_o  output  NUM_REGS  per-register stall (1 = hold); bit i drives pipeline register i.
- pc_stall_o  output  1  hold the PC.
- imem_read_o  output  1  issue/keep instruction read.
- dmem_req_o  output  1  issue/keep data access.
- stall_cycles_o  output  CNT_W  cycles the pipeline did not advance.
- imiss_cycles_o  output  CNT_W  cycles waiting on instruction memory.
- dmiss_cycles_o  output  CNT_W  cycles waiting on data memory.

## Operation
- State: i_done, d_done flags (response already received for current pipeline step); three counters.
- i_ok = ~imem_req_i | i_done | imem_resp_i; d_ok = ~dmem_req_i | d_done | dmem_resp_i.
- advance = i_ok & d_ok & ~rst.
- stall_o = {NUM_REGS{~advance}}; pc_stall_o = ~advance. All registers move in lockstep.
- imem_read_o = imem_req_i & ~i_done & ~rst; dmem_req_o = dmem_req_i & ~d_done & ~rst. A port whose response is latched is not re-requested.
- Flag update per edge: if advance, both flags clear to 0. Else i_done sets if imem_req_i & imem_resp_i; d_done sets if dmem_req_i & dmem_resp_i. A set flag holds until advance.
- Response with its req_i low: ignored, no flag set.
- Response while flag already set: ignored (protocol error), flag stays 1.
- Counters: stall_cycles increments when ~advance; imiss when imem_req_i & ~i_done & ~imem_resp_i; dmiss when dmem_req_i & ~d_done & ~dmem_resp_i. Each saturates at 2^CNT_W-1. clear_cnt_i has priority over increment (counter becomes 0 that edge).

## Timing
- Reset (rst high, async): i_done=d_done=0, all counters 0 immediately; while rst high stall_o all ones, pc_stall_o=1, imem_read_o=0, dmem_req_o=0.
- Outputs are combinational from inputs and flags: zero-cycle latency from resp to advance.
- Both responses in same cycle: advance that cycle, no flag ever set.
- Instruction first, data N cycles later: i_done=1 from next edge, imem_read_o drops next cycle, advance in data-response cycle, flags 0 after that edge.
- Data first: symmetric with d_done.
- Reset asserted mid-stall: flags cleared asynchronously; on deassertion controller starts with no responses latched (outstanding responses must be discarded by memory side).
- Counter increments and flag clears take effect at the same edge as advance.

## Test plan
- Reset: assert rst with all inputs 1 -> stall_o=4'b1111, pc_stall_o=1, imem_read_o=0, counters 0; release -> stall_o=0 with imem_req_i=imem_resp_i=1, dmem_req_i=0.
- No data access, imem_resp after 3 wait cycles -> stall_o=1111 for 3 cycles then 0000; stall_cycles_o=3, imiss_cycles_o=3, dmiss_cycles_o=0.
- Load with imem_resp at cycle 1, dmem_resp at cycle 4 -> i_done=1 cycles 2-4, imem_read_o=0 cycles 2-4, advance at cycle 4, stall_cycles_o=4, dmiss_cycles_o=4, imiss_cycles_o=1.
- Store with dmem_resp at cycle 2, imem_resp at cycle 5 -> d_done latched, dmem_req_o=0 cycles 3-5, advance at cycle 5, flags 0 at cycle 6.
- Simultaneous imem_resp and dmem_resp on first request cycle -> advance same cycle, flags never set, counters unchanged.
- CNT_W=8, hold imem_resp_i=0 for 300 cycles -> stall_cycles_o saturates at 255; clear_cnt_i pulse during stall -> 0 next edge, increments from following cycle.
